// File: rtl/chip8_pkg.sv
// chip8_pkg: opcode codes shared by the CHIP-8 decode pipeline and its users,
// the skid-buffer state type, and the combinational opcode classifier.
//   OP_*          : 6-bit decode codes, 0 = ILLEGAL, 1-35 CHIP-8, 36-44 SUPER-CHIP
//   skid_state_t  : occupancy of the two-entry skid buffer
//   chip8_decode  : maps a 16-bit instruction word to its decode code
package chip8_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_ILLEGAL     = 6'd0;
    localparam logic [OP_W-1:0] OP_CLS         = 6'd1;
    localparam logic [OP_W-1:0] OP_RET         = 6'd2;
    localparam logic [OP_W-1:0] OP_JMP_ADDR    = 6'd3;
    localparam logic [OP_W-1:0] OP_CALL_ADDR   = 6'd4;
    localparam logic [OP_W-1:0] OP_SE_VX_VAL   = 6'd5;
    localparam logic [OP_W-1:0] OP_SNE_VX_VAL  = 6'd6;
    localparam logic [OP_W-1:0] OP_SE_VX_VY    = 6'd7;
    localparam logic [OP_W-1:0] OP_LD_VX_VAL   = 6'd8;
    localparam logic [OP_W-1:0] OP_ADD_VX_VAL  = 6'd9;
    localparam logic [OP_W-1:0] OP_LD_VX_VY    = 6'd10;
    localparam logic [OP_W-1:0] OP_OR_VX_VY    = 6'd11;
    localparam logic [OP_W-1:0] OP_AND_VX_VY   = 6'd12;
    localparam logic [OP_W-1:0] OP_XOR_VX_VY   = 6'd13;
    localparam logic [OP_W-1:0] OP_ADD_VX_VY   = 6'd14;
    localparam logic [OP_W-1:0] OP_SUB_VX_VY   = 6'd15;
    localparam logic [OP_W-1:0] OP_SHR_VX      = 6'd16;
    localparam logic [OP_W-1:0] OP_SUBN_VX_VY  = 6'd17;
    localparam logic [OP_W-1:0] OP_SHL_VX      = 6'd18;
    localparam logic [OP_W-1:0] OP_SNE_VX_VY   = 6'd19;
    localparam logic [OP_W-1:0] OP_LD_I_ADDR   = 6'd20;
    localparam logic [OP_W-1:0] OP_JMP_V0_ADDR = 6'd21;
    localparam logic [OP_W-1:0] OP_RAND_VX_VAL = 6'd22;
    localparam logic [OP_W-1:0] OP_DRW_VX_VY   = 6'd23;
    localparam logic [OP_W-1:0] OP_SKP_VX      = 6'd24;
    localparam logic [OP_W-1:0] OP_SKNP_VX     = 6'd25;
    localparam logic [OP_W-1:0] OP_LD_VX_DT    = 6'd26;
    localparam logic [OP_W-1:0] OP_LD_VX_K     = 6'd27;
    localparam logic [OP_W-1:0] OP_LD_DT_VX    = 6'd28;
    localparam logic [OP_W-1:0] OP_LD_ST_VX    = 6'd29;
    localparam logic [OP_W-1:0] OP_ADD_I_VX    = 6'd30;
    localparam logic [OP_W-1:0] OP_LD_F_VX     = 6'd31;
    localparam logic [OP_W-1:0] OP_LD_B_VX     = 6'd32;
    localparam logic [OP_W-1:0] OP_LD_I_VX     = 6'd33;
    localparam logic [OP_W-1:0] OP_LD_VX_I     = 6'd34;
    localparam logic [OP_W-1:0] OP_SYS_ADDR    = 6'd35;
    localparam logic [OP_W-1:0] OP_SCD         = 6'd36;
    localparam logic [OP_W-1:0] OP_SCR         = 6'd37;
    localparam logic [OP_W-1:0] OP_SCL         = 6'd38;
    localparam logic [OP_W-1:0] OP_EXIT        = 6'd39;
    localparam logic [OP_W-1:0] OP_LOW         = 6'd40;
    localparam logic [OP_W-1:0] OP_HIGH        = 6'd41;
    localparam logic [OP_W-1:0] OP_LD_HF_VX    = 6'd42;
    localparam logic [OP_W-1:0] OP_LD_R_VX     = 6'd43;
    localparam logic [OP_W-1:0] OP_LD_VX_R     = 6'd44;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

    // 0nnn is SYS except for the 00xx words owned by CHIP-8 (00E0/00EE) and
    // by SUPER-CHIP (00Cn, 00FB-00FF); the latter are reserved, so they
    // decode ILLEGAL rather than SYS when SUPER-CHIP is disabled.
    function automatic logic [OP_W-1:0] chip8_decode(input logic [15:0] ins,
                                                     input logic        schip_en);
        logic [OP_W-1:0] op;
        logic [7:0]      kk;
        logic [3:0]      n;
        op = OP_ILLEGAL;
        kk = ins[7:0];
        n  = ins[3:0];
        case (ins[15:12])
            4'h0: begin
                if (ins[11:8] != 4'h0)      op = OP_SYS_ADDR;
                else if (kk[7:4] == 4'hC)   op = schip_en ? OP_SCD : OP_ILLEGAL;
                else begin
                    case (kk)
                        8'hE0:   op = OP_CLS;
                        8'hEE:   op = OP_RET;
                        8'hFB:   op = schip_en ? OP_SCR  : OP_ILLEGAL;
                        8'hFC:   op = schip_en ? OP_SCL  : OP_ILLEGAL;
                        8'hFD:   op = schip_en ? OP_EXIT : OP_ILLEGAL;
                        8'hFE:   op = schip_en ? OP_LOW  : OP_ILLEGAL;
                        8'hFF:   op = schip_en ? OP_HIGH : OP_ILLEGAL;
                        default: op = OP_SYS_ADDR;
                    endcase
                end
            end
            4'h1: op = OP_JMP_ADDR;
            4'h2: op = OP_CALL_ADDR;
            4'h3: op = OP_SE_VX_VAL;
            4'h4: op = OP_SNE_VX_VAL;
            4'h5: op = (n == 4'h0) ? OP_SE_VX_VY : OP_ILLEGAL;
            4'h6: op = OP_LD_VX_VAL;
            4'h7: op = OP_ADD_VX_VAL;
            4'h8: begin
                // 8xy0..8xy7 are contiguous codes starting at LD_VX_VY
                if (n <= 4'h7)       op = OP_LD_VX_VY + {2'b00, n};
                else if (n == 4'hE)  op = OP_SHL_VX;
                else                 op = OP_ILLEGAL;
            end
            4'h9: op = (n == 4'h0) ? OP_SNE_VX_VY : OP_ILLEGAL;
            4'hA: op = OP_LD_I_ADDR;
            4'hB: op = OP_JMP_V0_ADDR;
            4'hC: op = OP_RAND_VX_VAL;
            4'hD: op = OP_DRW_VX_VY;
            4'hE: begin
                case (kk)
                    8'h9E:   op = OP_SKP_VX;
                    8'hA1:   op = OP_SKNP_VX;
                    default: op = OP_ILLEGAL;
                endcase
            end
            default: begin
                case (kk)
                    8'h07:   op = OP_LD_VX_DT;
                    8'h0A:   op = OP_LD_VX_K;
                    8'h15:   op = OP_LD_DT_VX;
                    8'h18:   op = OP_LD_ST_VX;
                    8'h1E:   op = OP_ADD_I_VX;
                    8'h29:   op = OP_LD_F_VX;
                    8'h33:   op = OP_LD_B_VX;
                    8'h55:   op = OP_LD_I_VX;
                    8'h65:   op = OP_LD_VX_I;
                    8'h30:   op = schip_en ? OP_LD_HF_VX : OP_ILLEGAL;
                    8'h75:   op = schip_en ? OP_LD_R_VX  : OP_ILLEGAL;
                    8'h85:   op = schip_en ? OP_LD_VX_R  : OP_ILLEGAL;
                    default: op = OP_ILLEGAL;
                endcase
            end
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_pipe_if.sv
// decode_pipe_if: instruction-in / decoded-entry-out handshake bundle.
//   master : producer/consumer side (drives in_valid, instruction, in_pc,
//            flush, out_ready)
//   slave  : decode_pipe side (drives in_ready, out_valid, decoded fields,
//            out_pc, illegal_cnt)
interface decode_pipe_if #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [15:0]              instruction;
    logic [ADDR_W-1:0]        in_pc;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [chip8_pkg::OP_W-1:0] decode;
    logic [3:0]               x;
    logic [3:0]               y;
    logic [3:0]               nib;
    logic [7:0]               val;
    logic [11:0]              addr_out;
    logic [ADDR_W-1:0]        out_pc;
    logic [CNT_W-1:0]         illegal_cnt;

    modport master (
        output in_valid, instruction, in_pc, flush, out_ready,
        input  in_ready, out_valid, decode, x, y, nib, val, addr_out, out_pc, illegal_cnt
    );

    modport slave (
        input  in_valid, instruction, in_pc, flush, out_ready,
        output in_ready, out_valid, decode, x, y, nib, val, addr_out, out_pc, illegal_cnt
    );
endinterface

// File: rtl/decode_skid.sv
// decode_skid: two-entry (main + skid) valid/ready buffer with flush.
//   clk, rst              : clock, synchronous active-high reset
//   flush                 : empty the buffer next cycle, drop same-cycle input
//   in_valid/in_ready     : input handshake; in_ready is a flop (low only when FULL)
//   in_data               : W-bit payload
//   out_valid/out_ready   : output handshake; out_data always comes from main
//   out_data              : W-bit payload of the oldest held entry
import chip8_pkg::*;

module decode_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         in_xfer, out_xfer;

    always_comb begin
        in_xfer  = in_valid & in_ready_q & ~flush;
        out_xfer = out_valid_q & out_ready;
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        case (state_q)
            SKID_EMPTY: begin
                if (in_xfer) begin
                    main_d  = in_data;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = in_data;
                end else if (in_xfer) begin
                    // downstream stalled: park the new word behind main
                    skid_d  = in_data;
                    state_d = SKID_FULL;
                end else if (out_xfer) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        if (flush) state_d = SKID_EMPTY;
        // handshake outputs are registered from the next state
        in_ready_d  = (state_d != SKID_FULL);
        out_valid_d = (state_d != SKID_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SKID_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: CHIP-8 / SUPER-CHIP instruction decoder in front of a
// two-entry skid buffer, with a saturating count of ILLEGAL entries.
//   clk, rst : clock, synchronous active-high reset
//   bus      : decode_pipe_if.slave
//              in:  in_valid, instruction, in_pc, flush, out_ready
//              out: in_ready, out_valid, decode, x, y, nib, val, addr_out,
//                   out_pc, illegal_cnt
import chip8_pkg::*;

module decode_pipe #(
    parameter bit SCHIP_EN = 1'b0,
    parameter int ADDR_W   = 12,
    parameter int CNT_W    = 8
) (
    input  logic          clk,
    input  logic          rst,
    decode_pipe_if.slave  bus
);

    localparam int PW = OP_W + 16 + ADDR_W;

    logic [OP_W-1:0]  dec_code;
    logic [PW-1:0]    in_payload;
    logic [PW-1:0]    out_payload;
    logic             out_valid;
    logic [OP_W-1:0]  out_code;
    logic [15:0]      out_ins;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

    // decode happens before storage so the buffer carries the finished code
    always_comb begin
        dec_code   = chip8_decode(bus.instruction, SCHIP_EN);
        in_payload = {dec_code, bus.instruction, bus.in_pc};
    end

    decode_skid #(.W(PW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_payload)
    );

    assign out_code = out_payload[PW-1 -: OP_W];
    assign out_ins  = out_payload[ADDR_W +: 16];

    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (out_valid && bus.out_ready && (out_code == OP_ILLEGAL) &&
            (illegal_cnt_q != {CNT_W{1'b1}})) begin
            illegal_cnt_d = illegal_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) illegal_cnt_q <= '0;
        else     illegal_cnt_q <= illegal_cnt_d;
    end

    assign bus.out_valid   = out_valid;
    assign bus.decode      = out_code;
    assign bus.x           = out_ins[11:8];
    assign bus.y           = out_ins[7:4];
    assign bus.nib         = out_ins[3:0];
    assign bus.val         = out_ins[7:0];
    assign bus.addr_out    = out_ins[11:0];
    assign bus.out_pc      = out_payload[ADDR_W-1:0];
    assign bus.illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: two decode_pipe instances (SUPER-CHIP off with a 2-bit
// counter, SUPER-CHIP on with an 8-bit counter) driven by identical stimulus
// and compared every cycle against a queue-based model with a mask/match
// opcode table.
module tb_decode_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    decode_pipe_if #(.ADDR_W(12), .CNT_W(2)) ifa ();
    decode_pipe_if #(.ADDR_W(12), .CNT_W(8)) ifb ();

    decode_pipe #(.SCHIP_EN(1'b0), .ADDR_W(12), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    decode_pipe #(.SCHIP_EN(1'b1), .ADDR_W(12), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [15:0] m; logic [15:0] v; int code; bit s; } pat_t;
    pat_t tbl[$];

    task automatic add(input logic [15:0] m, input logic [15:0] v, input int c, input bit s);
        pat_t p;
        p.m = m; p.v = v; p.code = c; p.s = s;
        tbl.push_back(p);
    endtask

    task automatic build_table();
        add(16'hFFFF, 16'h00E0, 1, 0);  add(16'hFFFF, 16'h00EE, 2, 0);
        add(16'hFFF0, 16'h00C0, 36, 1);
        for (int k = 0; k < 5; k++) add(16'hFFFF, 16'h00FB + 16'(k), 37 + k, 1);
        add(16'hF000, 16'h0000, 35, 0);
        add(16'hF000, 16'h1000, 3, 0);  add(16'hF000, 16'h2000, 4, 0);
        add(16'hF000, 16'h3000, 5, 0);  add(16'hF000, 16'h4000, 6, 0);
        add(16'hF00F, 16'h5000, 7, 0);  add(16'hF000, 16'h6000, 8, 0);
        add(16'hF000, 16'h7000, 9, 0);
        for (int k = 0; k < 8; k++) add(16'hF00F, 16'h8000 + 16'(k), 10 + k, 0);
        add(16'hF00F, 16'h800E, 18, 0); add(16'hF00F, 16'h9000, 19, 0);
        add(16'hF000, 16'hA000, 20, 0); add(16'hF000, 16'hB000, 21, 0);
        add(16'hF000, 16'hC000, 22, 0); add(16'hF000, 16'hD000, 23, 0);
        add(16'hF0FF, 16'hE09E, 24, 0); add(16'hF0FF, 16'hE0A1, 25, 0);
        add(16'hF0FF, 16'hF007, 26, 0); add(16'hF0FF, 16'hF00A, 27, 0);
        add(16'hF0FF, 16'hF015, 28, 0); add(16'hF0FF, 16'hF018, 29, 0);
        add(16'hF0FF, 16'hF01E, 30, 0); add(16'hF0FF, 16'hF029, 31, 0);
        add(16'hF0FF, 16'hF033, 32, 0); add(16'hF0FF, 16'hF055, 33, 0);
        add(16'hF0FF, 16'hF065, 34, 0); add(16'hF0FF, 16'hF030, 42, 1);
        add(16'hF0FF, 16'hF075, 43, 1); add(16'hF0FF, 16'hF085, 44, 1);
    endtask

    function automatic int ref_decode(input logic [15:0] ins, input bit schip);
        foreach (tbl[i]) begin
            if ((ins & tbl[i].m) == tbl[i].v) return (tbl[i].s && !schip) ? 0 : tbl[i].code;
        end
        return 0;
    endfunction

    typedef struct { logic [15:0] ins; logic [11:0] pc; } ent_t;
    ent_t q[$];
    int   cnt_a = 0;
    int   cnt_b = 0;
    bit   zero_flds = 1'b1;

    // One clock: drive inputs, advance the model at the edge, check 1 time unit later.
    task automatic cycle(input bit r, input bit fl, input bit iv,
                         input logic [15:0] ins, input logic [11:0] pc, input bit ordy);
        bit   in_x, out_x;
        ent_t e;
        rst = r;
        ifa.flush = fl;  ifb.flush = fl;
        ifa.in_valid = iv;  ifb.in_valid = iv;
        ifa.instruction = ins;  ifb.instruction = ins;
        ifa.in_pc = pc;  ifb.in_pc = pc;
        ifa.out_ready = ordy;  ifb.out_ready = ordy;
        @(posedge clk);
        in_x  = iv && (q.size() < 2) && !fl;
        out_x = (q.size() > 0) && ordy;
        if (r) begin
            q.delete();
            cnt_a = 0; cnt_b = 0;
            zero_flds = 1'b1;
        end else begin
            if (out_x) begin
                if (ref_decode(q[0].ins, 1'b0) == 0 && cnt_a < 3)   cnt_a++;
                if (ref_decode(q[0].ins, 1'b1) == 0 && cnt_b < 255) cnt_b++;
            end
            if (fl) q.delete();
            else begin
                if (out_x) void'(q.pop_front());
                if (in_x) begin
                    e.ins = ins; e.pc = pc;
                    q.push_back(e);
                    zero_flds = 1'b0;
                end
            end
        end
        #1;
        chk("a_out_valid", 32'(ifa.out_valid), 32'(q.size() > 0));
        chk("b_out_valid", 32'(ifb.out_valid), 32'(q.size() > 0));
        chk("a_in_ready", 32'(ifa.in_ready), 32'(q.size() < 2));
        chk("b_in_ready", 32'(ifb.in_ready), 32'(q.size() < 2));
        chk("a_illegal_cnt", 32'(ifa.illegal_cnt), 32'(cnt_a));
        chk("b_illegal_cnt", 32'(ifb.illegal_cnt), 32'(cnt_b));
        if (q.size() > 0) begin
            chk("a_decode", 32'(ifa.decode), 32'(ref_decode(q[0].ins, 1'b0)));
            chk("b_decode", 32'(ifb.decode), 32'(ref_decode(q[0].ins, 1'b1)));
            chk("x", 32'(ifa.x), 32'(q[0].ins[11:8]));
            chk("y", 32'(ifb.y), 32'(q[0].ins[7:4]));
            chk("nib", 32'(ifa.nib), 32'(q[0].ins[3:0]));
            chk("val", 32'(ifb.val), 32'(q[0].ins[7:0]));
            chk("addr_out", 32'(ifa.addr_out), 32'(q[0].ins[11:0]));
            chk("out_pc", 32'(ifb.out_pc), 32'(q[0].pc));
        end else if (zero_flds) begin
            chk("rst_decode", 32'(ifa.decode) | 32'(ifb.decode), 32'd0);
            chk("rst_fields", {ifa.x, ifa.y, ifa.nib, ifb.val, ifb.nib}, 32'd0);
            chk("rst_addr_pc", {ifa.addr_out, ifb.out_pc}, 32'd0);
        end
    endtask

    function automatic logic [15:0] gen_ins();
        logic [7:0] lows [26] = '{8'hE0, 8'hEE, 8'hC5, 8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'hFF,
                                  8'h07, 8'h0A, 8'h15, 8'h18, 8'h1E, 8'h29, 8'h33, 8'h55,
                                  8'h65, 8'h30, 8'h75, 8'h85, 8'h9E, 8'hA1, 8'h00, 8'h08,
                                  8'h0E, 8'h01};
        logic [15:0] w;
        int sel;
        w   = 16'($urandom);
        sel = int'($urandom_range(0, 3));
        if (sel == 0)      w = {8'h00, lows[$urandom_range(0, 25)]};
        else if (sel == 1) w[7:0] = lows[$urandom_range(0, 25)];
        else if (sel == 2) w[3:0] = 4'($urandom_range(0, 15) & 32'h9 | ($urandom_range(0, 1) ? 32'hE : 32'h0));
        return w;
    endfunction

    initial begin
        logic [15:0] s37 [4] = '{16'h00E0, 16'h1234, 16'h6A5F, 16'hD125};
        int          c37 [4] = '{1, 3, 8, 23};
        int          c41 [5] = '{1, 2, 3, 3, 3};
        int          budget;

        build_table();
        ifa.in_valid = 0; ifb.in_valid = 0; ifa.flush = 0; ifb.flush = 0;
        ifa.out_ready = 0; ifb.out_ready = 0;
        ifa.instruction = 0; ifb.instruction = 0; ifa.in_pc = 0; ifb.in_pc = 0;

        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);

        // basic stream, one-cycle latency
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, s37[i], 12'(16 + i), 1);
            chk("stream_decode", 32'(ifb.decode), 32'(c37[i]));
        end
        chk("stream_nib", 32'(ifa.nib), 32'h5);
        cycle(0, 0, 0, 0, 0, 1);

        // SUPER-CHIP on vs off
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 16'h00FF, 12'h200, 1);
        chk("schip_off_00FF", 32'(ifa.decode), 32'd0);
        chk("schip_on_00FF", 32'(ifb.decode), 32'd41);
        cycle(0, 0, 1, 16'hF130, 12'h202, 1);
        chk("schip_off_F130", 32'(ifa.decode), 32'd0);
        chk("schip_on_F130", 32'(ifb.decode), 32'd42);
        cycle(0, 0, 0, 0, 0, 1);
        chk("schip_off_cnt", 32'(ifa.illegal_cnt), 32'd2);
        chk("schip_on_cnt", 32'(ifb.illegal_cnt), 32'd0);

        // backpressure with continuous input
        cycle(0, 0, 1, 16'h6101, 12'h300, 0);
        cycle(0, 0, 1, 16'h6202, 12'h302, 0);
        chk("bp_full_in_ready", 32'(ifa.in_ready), 32'd0);
        cycle(0, 0, 1, 16'h6303, 12'h304, 0);
        chk("bp_hold_val", 32'(ifa.val), 32'h01);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 16'h6303, 12'h304, 1);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);

        // flush while FULL with a word offered
        cycle(0, 0, 1, 16'hA111, 12'h400, 0);
        cycle(0, 0, 1, 16'hA222, 12'h402, 0);
        cycle(0, 1, 1, 16'hA333, 12'h404, 0);
        chk("flush_out_valid", 32'(ifb.out_valid), 32'd0);
        chk("flush_in_ready", 32'(ifb.in_ready), 32'd1);
        cycle(0, 0, 0, 0, 0, 1);
        chk("flush_no_ghost", 32'(ifa.out_valid), 32'd0);

        // counter saturation on the 2-bit instance
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 16'h8008, 12'h500, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, (i < 4), 16'h8008, 12'(12'h502 + 2 * i), 1);
            chk("sat_cnt", 32'(ifa.illegal_cnt), 32'(c41[i]));
        end

        // reset while FULL
        cycle(0, 0, 1, 16'h7A7A, 12'h600, 0);
        cycle(0, 0, 1, 16'h7B7B, 12'h602, 0);
        cycle(1, 0, 1, 16'h7C7C, 12'h604, 1);
        chk("rst_full_in_ready", 32'(ifb.in_ready), 32'd1);
        chk("rst_full_out", {ifb.out_valid, ifb.decode, ifb.out_pc, 8'(ifb.illegal_cnt)}, 32'd0);

        // randomized traffic
        budget = 3000;
        for (int i = 0; i < budget; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) < 7), gen_ins(), 12'($urandom),
                  ($urandom_range(0, 9) < 6));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
